memory_arbiter: RTL

Two-requester arbiter and sequencer for the single core memory port. Instruction fetch (PC-driven, always read, full-word mask) and load/store (read or write, byte mask) share that port. The block latches one request at a time, drives the port until the memory acknowledges, and returns the response to the winner. Load/store has priority, with a starvation guard for fetch and a watchdog against a hung memory.

---
 rtl/memory_pkg.sv | 31 +++
 rtl/memory_watchdog.sv | 32 +++
 rtl/memory_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the core memory-port arbiter.
// Access direction, full mask, arbiter states and the latched request.
package memory_pkg;

  localparam logic       READ      = 1'b0;
  localparam logic       WRITE     = 1'b1;
  localparam logic [3:0] FULL_MASK = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DATA    = 2'd2,
    S_RESPOND = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic        state;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mem_req_t;

  // Writes return no data to the requester.
  function automatic logic [31:0] resp_data(
    input logic        is_write,
    input logic [31:0] rdata
  );
    return is_write ? 32'd0 : rdata;
  endfunction

endpackage

// File: rtl/memory_watchdog.sv
// Loadable down-counter guarding a memory access against a hung port.
// Expires on the last enabled cycle of the loaded budget.
module memory_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] LOAD_VAL = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_enable && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_expired = i_enable && (r_count == 8'd1);

endmodule

// File: rtl/memory_arbiter.sv
// Fetch / load-store arbiter and sequencer for the single memory port.
// Data has priority; a starvation counter eventually forces a fetch grant.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_request,
  input  logic [31:0] fetch_address,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic        data_request,
  input  logic        data_state,
  input  logic [31:0] data_address,
  input  logic [3:0]  data_frame_mask,
  input  logic [31:0] data_write_data,
  output logic        data_ready,
  output logic [31:0] data_read_data,
  output logic        mem_enable,
  output logic        mem_state,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_frame_mask,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_done,
  output logic        mem_timeout
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  r_state;
  mem_req_t    r_req;
  logic [3:0]  r_starve;
  logic        r_mem_enable;
  logic        r_fetch_ready;
  logic        r_data_ready;
  logic        r_timeout;
  logic [31:0] r_fetch_data;
  logic [31:0] r_data_read_data;

  logic w_any_req;
  logic w_starved;
  logic w_pick_fetch;
  logic w_busy;
  logic w_grant;
  logic w_finish;
  logic w_wd_clear;
  logic w_expired;

  assign w_any_req    = fetch_request | data_request;
  assign w_starved    = (r_starve == LIMIT);
  assign w_pick_fetch = fetch_request & (~data_request | w_starved);
  assign w_busy       = (r_state == S_FETCH) | (r_state == S_DATA);
  assign w_grant      = (r_state == S_IDLE) & w_any_req;
  assign w_wd_clear   = (r_state == S_RESPOND);
  assign w_finish     = mem_done | w_expired;

  memory_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_load    (w_grant),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_req            <= '0;
      r_starve         <= 4'd0;
      r_mem_enable     <= 1'b0;
      r_fetch_ready    <= 1'b0;
      r_data_ready     <= 1'b0;
      r_timeout        <= 1'b0;
      r_fetch_data     <= 32'd0;
      r_data_read_data <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_mem_enable <= 1'b1;
            if (w_pick_fetch) begin
              r_state  <= S_FETCH;
              r_starve <= 4'd0;
              r_req    <= '{state: READ,
                            addr:  fetch_address,
                            mask:  FULL_MASK,
                            wdata: 32'd0};
            end else begin
              r_state <= S_DATA;
              r_req   <= '{state: data_state,
                           addr:  data_address,
                           mask:  data_frame_mask,
                           wdata: data_write_data};
              if (fetch_request && (r_starve < LIMIT)) begin
                r_starve <= r_starve + 4'd1;
              end
            end
          end
        end
        S_FETCH, S_DATA: begin
          // mem_done on the expiry edge still counts as success
          if (w_finish) begin
            r_mem_enable <= 1'b0;
            r_state      <= S_RESPOND;
            if (!mem_done) begin
              r_timeout <= 1'b1;
            end
            if (r_state == S_FETCH) begin
              r_fetch_ready <= 1'b1;
              r_fetch_data  <= mem_done ? mem_read_data : 32'd0;
            end else begin
              r_data_ready     <= 1'b1;
              r_data_read_data <= mem_done ?
                resp_data(r_req.state, mem_read_data) : 32'd0;
            end
          end
        end
        S_RESPOND: begin
          r_fetch_ready <= 1'b0;
          r_data_ready  <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_enable     = r_mem_enable;
  assign mem_state      = r_req.state;
  assign mem_address    = r_req.addr;
  assign mem_frame_mask = r_req.mask;
  assign mem_write_data = r_req.wdata;
  assign fetch_ready    = r_fetch_ready;
  assign fetch_data     = r_fetch_data;
  assign data_ready     = r_data_ready;
  assign data_read_data = r_data_read_data;
  assign mem_timeout    = r_timeout;

endmodule
